// File: rtl/spi_pkg.sv
// Shared definitions for the SPI burst memory: FSM state codes, RW bit
// values and a max() helper used to size the bit counter.
package spi_pkg;

  // Frame FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] ADDR = 2'd2;
  localparam logic [1:0] DATA = 2'd3;

  // Value of the leading RW bit of a frame
  localparam logic SPI_RD = 1'b1;
  localparam logic SPI_WR = 1'b0;

  function automatic int unsigned max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a third stage for edge detection.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   din        : asynchronous input
//   level      : synchronised level (reset to RST_VAL)
//   rise_c     : combinational one-cycle pulse on a synchronised rising edge
//   fall_c     : combinational one-cycle pulse on a synchronised falling edge
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic meta;
  logic prev;

  // meta/level form the synchroniser, prev holds last cycle's level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= RST_VAL;
      level <= RST_VAL;
      prev  <= RST_VAL;
    end else begin
      meta  <= din;
      level <= meta;
      prev  <= level;
    end
  end

  assign rise_c = level & ~prev;
  assign fall_c = ~level & prev;

endmodule

// File: rtl/spi_burst_mem.sv
// SPI slave memory with configurable address/data widths, any SPI mode and
// auto-incrementing bursts. All SPI pins are oversampled in the CLK domain.
// Ports:
//   CLK, RST_N : system clock, async active-low reset
//   SCLK, CS   : SPI clock and active-low chip select (asynchronous)
//   MOSI       : serial data in, MSB first
//   MISO       : serial data out, MSB first, high-Z unless in a read data phase
//   BUSY       : high while a frame is active
module spi_burst_mem
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8,
  parameter bit          CPOL   = 1'b0,
  parameter bit          CPHA   = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SCLK,
  input  logic CS,
  input  logic MOSI,
  output logic MISO,
  output logic BUSY
);

  localparam int unsigned CNT_W = $clog2(max(ADDR_W, DATA_W) + 1);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic              sclk_lvl, sclk_rise_c, sclk_fall_c;
  logic              cs_lvl, cs_rise_c, cs_fall_c;
  logic              mosi_meta, mosi_s;
  logic [1:0]        sync_vld;
  logic              armed;
  logic [1:0]        state, state_nx;
  logic              drive_en;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic              rw;
  logic [DATA_W-1:0] rx, tx;
  logic              wr_pend;
  logic [DATA_W-1:0] mem [DEPTH];

  logic lead_c, trail_c, sample_c, shift_c, start_c;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sclk_sync (
    .clk(CLK), .rst_n(RST_N), .din(SCLK),
    .level(sclk_lvl), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(CLK), .rst_n(RST_N), .din(CS),
    .level(cs_lvl), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
  );

  // MOSI only needs a plain synchroniser; it is stable around sample edges
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= MOSI;
      mosi_s    <= mosi_meta;
    end
  end

  // Leading edge moves SCLK away from its idle level, trailing edge returns it
  assign lead_c   = (sclk_rise_c | sclk_fall_c) & (sclk_lvl != CPOL);
  assign trail_c  = (sclk_rise_c | sclk_fall_c) & (sclk_lvl == CPOL);
  assign sample_c = CPHA ? trail_c : lead_c;
  assign shift_c  = CPHA ? lead_c : trail_c;

  // The CS synchroniser resets to "deselected", so a CS held low across reset
  // release looks like a falling edge. Only accept a fall once a real high
  // level has been seen after reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && cs_lvl) armed <= 1'b1;
    end
  end

  assign start_c = cs_fall_c & armed;

  // Next-state logic; a CS rise wins over any concurrent SCLK edge
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_c) state_nx = CMD;
      CMD:     if (sample_c) state_nx = ADDR;
      ADDR:    if (sample_c && cnt == CNT_W'(ADDR_W - 1)) state_nx = DATA;
      default: state_nx = state;
    endcase
    if (cs_rise_c) state_nx = IDLE;
  end

  // State register and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      BUSY     <= 1'b0;
      drive_en <= 1'b0;
    end else begin
      state    <= state_nx;
      BUSY     <= (state_nx != IDLE);
      drive_en <= (state_nx == DATA) && (rw == SPI_RD);
    end
  end

  // Shift registers, bit counter and address counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt     <= '0;
      addr    <= '0;
      rw      <= SPI_WR;
      rx      <= '0;
      tx      <= '0;
      wr_pend <= 1'b0;
    end else begin
      wr_pend <= 1'b0;
      if (wr_pend) addr <= addr + ADDR_W'(1);
      case (state)
        IDLE: if (start_c) cnt <= '0;
        CMD: if (sample_c) begin
          rw  <= mosi_s;
          cnt <= '0;
        end
        ADDR: if (sample_c) begin
          addr <= {addr[ADDR_W-2:0], mosi_s};
          cnt  <= (cnt == CNT_W'(ADDR_W - 1)) ? '0 : cnt + CNT_W'(1);
        end
        default: begin
          if (rw == SPI_WR) begin
            // Full word commits next cycle even if CS rises alongside the last bit
            if (sample_c) begin
              rx <= {rx[DATA_W-2:0], mosi_s};
              if (cnt == CNT_W'(DATA_W - 1)) begin
                cnt     <= '0;
                wr_pend <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end else if (shift_c && !cs_rise_c) begin
            // Word boundary: fetch and post-increment, otherwise shift out
            if (cnt == '0) begin
              tx   <= mem[addr];
              addr <= addr + ADDR_W'(1);
            end else begin
              tx <= {tx[DATA_W-2:0], 1'b0};
            end
            cnt <= (cnt == CNT_W'(DATA_W - 1)) ? '0 : cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Storage array: not reset, contents survive RST_N
  always_ff @(posedge CLK) begin
    if (wr_pend) mem[addr] <= rx;
  end

  assign MISO = drive_en ? tx[DATA_W-1] : 1'bz;

endmodule

// File: doc/spi_burst_mem.md
# spi_burst_mem

Parametrised SPI slave memory: a serial host reads and writes a `2**ADDR_W` x `DATA_W` internal memory over MOSI/MISO/SCLK/CS. It extends the fixed 8-bit/7-bit-address, mode-0, single-word SPI memory with configurable widths, all four SPI modes, and auto-incrementing burst transfers. SCLK, CS and MOSI are oversampled in the system `CLK` domain. The block sits behind the board-level SPI pins as the register/scratch store for an external controller.

## Interface
Parameters:
- `ADDR_W`, 7: address bits per frame; memory depth is `2**ADDR_W`.
- `DATA_W`, 8: bits per data word.
- `CPOL`, 0: SCLK idle level.
- `CPHA`, 0: 0 = sample on the leading edge and shift on the trailing edge; 1 = shift on the leading edge and sample on the trailing edge.

Ports:
- `CLK`, in, 1: system clock; the only clock in the block.
- `RST_N`, in, 1: reset; asynchronous, active-low.
- `SCLK`, in, 1: SPI clock, asynchronous to `CLK`.
- `CS`, in, 1: chip select, active-low, asynchronous to `CLK`.
- `MOSI`, in, 1: serial data in, MSB first.
- `MISO`, out, 1: serial data out, MSB first; high-Z when not driving.
- `BUSY`, out, 1: high while a frame is active, meaning synchronised `CS` is low.

## Operation
- **Frame format.** One frame is delimited by `CS` low. It carries:
  - 1 RW bit (1 = read, 0 = write);
  - then `ADDR_W` address bits, MSB first;
  - then one or more `DATA_W`-bit words.
- **FSM states.**
  - `IDLE`: entered on the synchronised `CS` falling edge; moves to `CMD`.
  - `CMD`: after 1 sample edge, moves to `ADDR`.
  - `ADDR`: after `ADDR_W` sample edges, moves to `DATA`.
  - `DATA`: stays here until `CS` rises.
  - Any state goes to `IDLE` on synchronised `CS` high.
- **Write.**
  - Data bits shift into the RX register on sample edges.
  - After the `DATA_W`-th bit, `mem[addr]` is written on the next `CLK`. `addr` then increments modulo `2**ADDR_W` and the bit counter clears.
  - A partial word at `CS` rise is discarded.
- **Read.**
  - On the first shift edge after the last address bit is sampled, `mem[addr]` loads into the TX register and its MSB drives `MISO`.
  - Each later shift edge shifts the TX register left.
  - After `DATA_W` bits, the next shift edge loads `mem[addr+1]` (modulo `2**ADDR_W`).
- **MISO drive.** `MISO` is driven only in `DATA` of a read frame. In every other state, including the whole of a write frame, it is high-Z.
- **Bit counter.** Width is `$clog2(max(ADDR_W,DATA_W)+1)`. It saturates at nothing: it is reloaded at each field boundary.
- **Memory reset.** Memory contents are not reset. They are undefined at power-up and preserved across `RST_N`.

## Timing
- **Synchroniser path.** `SCLK`, `CS` and `MOSI` each pass a 2-flop synchroniser. SCLK edge detection adds 1 register stage, so an SCLK edge is acted on 3 `CLK` after it occurs.
- **SCLK rate.** The SCLK half-period must be at least 4 `CLK` periods. The bench uses 10 `CLK` per half-period.
- **MISO timing.** `MISO` changes 3–4 `CLK` after the shift edge and is stable well before the next sample edge.
- **Write commit.** A memory write occurs 1 `CLK` after the final data-bit sample is registered.
- **End of frame.** `BUSY` falls, and `MISO` goes high-Z, 3 `CLK` after `CS` rises.
- **Reset values.**
  - State = `IDLE`, `BUSY` = 0, `MISO` = z.
  - Counters, address and shift registers = 0.
  - Synchroniser flops reset to the idle levels: `CS`=1 and `SCLK`=`CPOL`.
- **Reset mid-frame.** Reset aborts immediately. The block then ignores SCLK until a fresh `CS` falling edge, so a `CS` held low through reset release starts no frame.
- **Simultaneous events.** A `CS` rise in the same `CLK` as the final write sample still commits the write. A `CS` rise and a shift edge in the same `CLK` resolve to `IDLE`.

## Structure
- **Package `spi_pkg`:**
  - state encoding (`IDLE`, `CMD`, `ADDR`, `DATA`);
  - RW constants (`SPI_RD`=1, `SPI_WR`=0);
  - the `max` helper function for counter sizing.
- **Sub-module `spi_sync_edge`:**
  - 2-flop synchroniser plus rise/fall detect, with a reset-value parameter;
  - instantiated for `SCLK` and `CS`;
  - `MOSI` uses the synchroniser only.
- **Top level:** the FSM, shift registers, address counter and the memory array.

## Test plan
All scenarios use `ADDR_W`=7, `DATA_W`=8, mode 0 unless stated otherwise.
- **Basic write/read.** Write frame `0`+`1010101`, data `00110011`; then read frame `1`+`1010101` → `MISO` = 0,0,1,1,0,0,1,1 on successive sample edges; `MISO` = z after `CS` high.
- **Burst with wrap.** Burst write at address 0x7F with data 0x11, 0x22, 0x33 → `mem[0x7F]`=0x11, `mem[0x00]`=0x22, `mem[0x01]`=0x33. A burst read from 0x7F returns the same three bytes.
- **Aborted write.** Write 0x10, drive 4 bits of 0xFF, then raise `CS` → `mem[0x10]` keeps its prior value 0x5A; `BUSY`=0 within 3 `CLK`.
- **Mode 3.** `CPOL`=1, `CPHA`=1 instance, same write/read as the basic scenario → identical `MISO` sequence, sampled on rising edges.
- **Reset mid-read.** Pulse `RST_N` low mid-read with `CS` held low → `MISO`=z and `BUSY`=0 immediately; further SCLK ignored. After `CS` high then low, a normal read returns 0x33.
- **Wide instance.** `ADDR_W`=4, `DATA_W`=16: write 0xA5C3 to 0x9 and read it back → 16 bits of 1010_0101_1100_0011, MSB first.
